// File: rtl/md_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_defs (package)
// Brief    : MDU op encodings, default latencies and busy-counter sizing.
// Revision : 1.0
// ============================================================================
package md_defs;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;

   function automatic int cnt_width(input int m, input int d);
      return $clog2(((m > d) ? m : d) + 1);
   endfunction

   localparam int CNT_W_DEF = cnt_width(MULT_CYC_DEF, DIV_CYC_DEF);

endpackage
`default_nettype wire

// File: rtl/md_calc.sv
`default_nettype none
// ============================================================================
// Module   : md_calc
// Brief    : Combinational mult/multu/div/divu datapath producing {hi, lo}.
// Revision : 1.0
// ============================================================================
module md_calc
   import md_defs::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] res,
   output logic        div0
);

   logic               b_zero;
   logic [31:0]        dvs;
   logic               s_ovf;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] q_s;
   logic signed [31:0] r_s;
   logic [31:0]        q_u;
   logic [31:0]        r_u;

   // A safe divisor keeps the divider free of X when b is zero; the result is discarded anyway.
   assign b_zero = (b == 32'd0);
   assign dvs    = b_zero ? 32'd1 : b;
   assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};
   assign q_s    = $signed(a) / $signed(dvs);
   assign r_s    = $signed(a) % $signed(dvs);
   assign q_u    = a / dvs;
   assign r_u    = a % dvs;

   always_comb begin
      res  = 64'd0;
      div0 = 1'b0;
      case (op)
         MD_MULT:  res = prod_s;
         MD_MULTU: res = prod_u;
         MD_DIV: begin
            div0 = b_zero;
            if (s_ovf) res = {32'd0, 32'h8000_0000};
            else       res = {r_s, q_s};
         end
         MD_DIVU: begin
            div0 = b_zero;
            res  = {r_u, q_u};
         end
         default: res = 64'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module   : md_sched
// Brief    : MDU scheduler: busy counter, pending result, HI/LO and stall.
// Revision : 1.0
// ============================================================================
module md_sched
   import md_defs::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        md_valid,
   input  logic [3:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_is_md,
   output logic        start,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   localparam int CNT_W = cnt_width(MULT_CYC, DIV_CYC);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      pend_q, pend_d;
   logic             pend_div0_q, pend_div0_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;

   logic [63:0]      calc_res;
   logic             calc_div0;
   logic             is_arith;
   logic             is_div;
   logic             idle_valid;

   md_calc u_calc (
      .op   (md_op),
      .a    (a),
      .b    (b),
      .res  (calc_res),
      .div0 (calc_div0)
   );

   assign busy       = (cnt_q != '0);
   assign is_arith   = (md_op >= MD_MULT) && (md_op <= MD_DIVU);
   assign is_div     = (md_op == MD_DIV) || (md_op == MD_DIVU);
   assign idle_valid = md_valid && !busy;
   assign start      = idle_valid && is_arith;
   assign stall      = d_is_md && (start || busy);
   assign hi         = hi_q;
   assign lo         = lo_q;

   always_comb begin
      md_out = 32'd0;
      if (idle_valid && (md_op == MD_MFHI)) md_out = hi_q;
      if (idle_valid && (md_op == MD_MFLO)) md_out = lo_q;
   end

   always_comb begin
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pend_div0_d = pend_div0_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      if (start) begin
         cnt_d       = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
         pend_d      = calc_res;
         pend_div0_d = calc_div0;
      end else if (busy) begin
         cnt_d = cnt_q - CNT_W'(1);
         // Last busy cycle: commit, except a divide by zero leaves HI/LO untouched.
         if ((cnt_q == CNT_W'(1)) && !pend_div0_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
         end
      end
      if (idle_valid && (md_op == MD_MTHI)) hi_d = a;
      if (idle_valid && (md_op == MD_MTLO)) lo_d = a;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         pend_q      <= 64'd0;
         pend_div0_q <= 1'b0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
      end else begin
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_div0_q <= pend_div0_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
      end
   end

   a_no_md_while_busy : assert property (
      @(posedge clk) disable iff (!reset_n)
      !(md_valid && (md_op != MD_NONE) && (md_op <= MD_MFLO) && busy)
   );

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sched
// Brief    : Directed self-checking bench for md_sched.
// Revision : 1.0
// ============================================================================
module tb_md_sched;

   logic        clk;
   logic        reset_n;
   logic        md_valid;
   logic [3:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_is_md;
   logic        start;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_out;

   int total = 0;
   int bad   = 0;

   md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .md_valid (md_valid),
      .md_op    (md_op),
      .a        (a),
      .b        (b),
      .d_is_md  (d_is_md),
      .start    (start),
      .busy     (busy),
      .stall    (stall),
      .hi       (hi),
      .lo       (lo),
      .md_out   (md_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues an arithmetic op and follows it cycle by cycle through commit.
   task automatic run_arith(input string tag, input logic [3:0] op, input logic [31:0] va,
                            input logic [31:0] vb, input int n, input logic dmd,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      md_valid = 1'b1; md_op = op; a = va; b = vb; d_is_md = dmd;
      #1;
      chk({tag, "_start"}, {31'd0, start}, 32'd1);
      chk({tag, "_stall_t"}, {31'd0, stall}, {31'd0, dmd});
      tick();
      md_valid = 1'b0; md_op = 4'd0; a = 32'd0; b = 32'd0;
      #1;
      for (int i = 1; i <= n; i++) begin
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_stall_busy"}, {31'd0, stall}, {31'd0, dmd});
         tick();
      end
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      chk({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
      d_is_md = 1'b0;
   endtask

   task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] va);
      md_valid = 1'b1; md_op = op; a = va;
      #1;
      chk({tag, "_nostart"}, {31'd0, start}, 32'd0);
      tick();
      md_valid = 1'b0; md_op = 4'd0; a = 32'd0;
      #1;
      chk({tag, "_nobusy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic move_from(input string tag, input logic [3:0] op, input logic [31:0] exp);
      md_valid = 1'b1; md_op = op;
      #1;
      chk(tag, md_out, exp);
      tick();
      md_valid = 1'b0; md_op = 4'd0;
   endtask

   initial begin
      reset_n = 1'b0; md_valid = 1'b0; md_op = 4'd0; a = 32'd0; b = 32'd0; d_is_md = 1'b0;
      repeat (3) tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_start", {31'd0, start}, 32'd0);
      chk("rst_mdout", md_out, 32'd0);
      reset_n = 1'b1;
      tick();

      // Reset mid-run aborts the mult; nothing commits afterwards.
      md_valid = 1'b1; md_op = 4'd1; a = 32'd3; b = 32'd4;
      #1;
      chk("abort_start", {31'd0, start}, 32'd1);
      tick();
      md_valid = 1'b0; md_op = 4'd0;
      tick();
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      tick();
      reset_n = 1'b1;
      repeat (8) tick();
      chk("abort_nocommit_hi", hi, 32'd0);
      chk("abort_nocommit_lo", lo, 32'd0);

      // Hazard: mflo sitting in D during the mult.
      run_arith("mult",  4'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_arith("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
      run_arith("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_arith("divu",  4'd4, 32'd7, 32'd2, 10, 1'b1, 32'd1, 32'd3);

      move_to("mthi11", 4'd5, 32'h11);
      move_to("mtlo22", 4'd6, 32'h22);
      chk("pre_div0_hi", hi, 32'h11);
      chk("pre_div0_lo", lo, 32'h22);
      run_arith("div0", 4'd3, 32'd100, 32'd0, 10, 1'b0, 32'h11, 32'h22);
      run_arith("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0, 32'h8000_0000);

      move_to("mthi", 4'd5, 32'hDEAD_BEEF);
      chk("mthi_hi", hi, 32'hDEAD_BEEF);
      chk("mthi_lo_kept", lo, 32'h8000_0000);
      move_from("mfhi", 4'd7, 32'hDEAD_BEEF);
      move_from("mflo", 4'd8, 32'h8000_0000);
      move_from("none_mdout", 4'd0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/md_sched.md
Name: md_sched

Overview:
- Controller and scheduler for the multiply/divide unit (MDU) and the HI/LO registers in the pipelined MIPS core.
- Accepts mult/div/mthi/mtlo/mfhi/mflo from the E stage and models the fixed multi-cycle MDU latency with a busy counter.
- Commits results to HI/LO and raises a stall request to the hazard unit when the D-stage instruction needs the MDU while it is occupied.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYC, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- md_valid  in  1  E-stage instruction valid (not a bubble)
- md_op  in  4  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
- a  in  32  forwarded rs value
- b  in  32  forwarded rt value
- d_is_md  in  1  D-stage instruction is any MDU op (1..8)
- start  out  1  MDU operation accepted this cycle
- busy  out  1  MDU operation in flight
- stall  out  1  stall request to the hazard unit (freeze F/D, bubble into E)
- hi  out  32  HI register
- lo  out  32  LO register
- md_out  out  32  E-stage mfhi/mflo result

Behaviour:
- Reset (reset_n=0, async): cnt=0, busy=0, hi=0, lo=0, pending result=0. start, stall and md_out follow from these. Reset mid-operation aborts it and no commit occurs.
- States: IDLE (cnt==0) and RUN (cnt!=0). busy = (cnt!=0).
- start (combinational) = md_valid & md_op in {1..4} & !busy.
- On start in cycle T:
  - cnt loads MULT_CYC or DIV_CYC.
  - The 64-bit result is latched into the pending registers at the T edge.
  - busy is high for cycles T+1..T+N.
  - At the edge ending the cycle with cnt==1, the pending result is written to HI/LO and cnt reaches 0. New HI/LO are visible from T+N+1.
- Arithmetic:
  - mult: signed 32x32 to 64; multu: unsigned. hi = product[63:32], lo = product[31:0].
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (b==0): the op still runs the full DIV_CYC busy period, and HI/LO stay unchanged at commit.
- mthi/mtlo: when md_valid & !busy, hi (resp. lo) <= a at the end of the cycle. Takes effect in one cycle with no busy period.
- mfhi/mflo: md_out = hi / lo combinationally, reading the current register value with no bypass. For any other op, md_out = 0.
- stall = d_is_md & (start | busy). This holds every MDU op in D until E is clear, so the E stage never presents an MDU op while busy.
- Protocol violation (md_valid with an MDU op while busy) is ignored: no state change, md_out = 0. Flag with a simulation assertion.
- No cancellation: a started op always commits unless reset.

Decomposition:
- Package md_defs holds:
  - MD_NONE..MD_MFLO op encodings (4 bits)
  - default MULT_CYC/DIV_CYC
  - counter width (clog2 of max(MULT_CYC, DIV_CYC) + 1)
- Sub-module md_calc (combinational):
  - inputs: op, a, b
  - outputs: 64-bit {hi, lo} result and a div0 flag
- md_sched holds the counter, the pending registers, HI/LO, and the start/stall logic.

Test Plan:
- Reset pulse mid-RUN (mult 3*4 in flight) -> busy=0, hi=lo=0 immediately; no commit afterwards.
- mult a=0xFFFFFFFF, b=2 at T -> start=1 at T, busy high T+1..T+5, then hi=0xFFFFFFFF, lo=0xFFFFFFFE at T+6. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 -> lo=3, hi=1.
- div with b=0 and hi=0x11, lo=0x22 beforehand -> busy for 10 cycles, HI/LO remain 0x11/0x22. Also div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Hazard timing, mult at T with d_is_md=1 (mflo in D) from T to T+5 -> stall=1 at T..T+5, stall=0 at T+6. With d_is_md=0, stall stays 0 while busy.
- mthi a=0xDEADBEEF while idle -> hi=0xDEADBEEF next cycle, busy never rises. Following mfhi -> md_out=0xDEADBEEF. mflo -> md_out=lo.
